// File: rtl/receptor_serial_defs_pkg.sv
// Shared definitions for the 16-bit serial receiver: FSM state encodings,
// default bit period and the even-parity helper used when RECEPTOR_PARIDADE_EN is defined.
package receptor_serial_defs_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned ESTADO_W             = 4;
    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned WORD_W               = 16;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        ARMAZENA = 4'd5,
        PRONTO   = 4'd6,
        ERRO     = 4'd7
    } estado_t;

    // High when data plus parity bit has odd weight, i.e. even parity is violated.
    function automatic logic paridade_impar(input logic [BYTE_W-1:0] dado, input logic bit_par);
        return ^{dado, bit_par};
    endfunction

endpackage

// File: rtl/contador_bit_serial.sv
// Modulo-MODULO bit timer with synchronous clear and enable; fim_o flags the
// terminal count and meio_o flags the half-bit point, both registered.
module contador_bit_serial #(
    parameter int unsigned MODULO = 434,
    parameter int unsigned MEIO   = MODULO / 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic fim_o,
    output logic meio_o
);

    localparam int unsigned W = $clog2(MODULO);

    logic [W-1:0] cnt_q, cnt_d;
    logic         fim_q, meio_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == W'(MODULO - 1)) ? '0 : cnt_q + W'(1);
        end
    end

    // Flags are registered from the next count so they line up with cnt_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            fim_q  <= 1'b0;
            meio_q <= (MEIO == 1);
        end else begin
            cnt_q  <= cnt_d;
            fim_q  <= (cnt_d == W'(MODULO - 1));
            meio_q <= (cnt_d == W'(MEIO - 1));
        end
    end

    assign fim_o  = fim_q;
    assign meio_o = meio_q;

endmodule

// File: rtl/receptor_serial_16.sv
// UART receiver (8N1, or 8E1 with RECEPTOR_PARIDADE_EN) that pairs two bytes into
// a 16-bit word {second, first} and pulses pronto for one cycle per word.
module receptor_serial_16
    import receptor_serial_defs_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                RX,
    output logic [WORD_W-1:0]   D,
    output logic                pronto,
    output logic                erro,
    output logic [ESTADO_W-1:0] db_estado
);

    logic               rx_meta_q, rx_s_q;
    estado_t            estado_q, estado_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic [BYTE_W-1:0]  low_q, low_d;
    logic               cnt_byte_q, cnt_byte_d;
    logic               espera_q, espera_d;
    logic [WORD_W-1:0]  d_q, d_d;
    logic               pronto_q, pronto_d;
    logic               erro_q, erro_d;
`ifdef RECEPTOR_PARIDADE_EN
    logic               par_q, par_d;
`endif
    logic               tmr_clr, tmr_en;
    logic               tmr_fim, tmr_meio;

    contador_bit_serial #(
        .MODULO (CLKS_PER_BIT),
        .MEIO   (HALF_BIT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .fim_o  (tmr_fim),
        .meio_o (tmr_meio)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        estado_d   = estado_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        low_d      = low_q;
        cnt_byte_d = cnt_byte_q;
        espera_d   = espera_q;
        d_d        = d_q;
`ifdef RECEPTOR_PARIDADE_EN
        par_d      = par_q;
`endif
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;

        case (estado_q)
            INICIAL: begin
                tmr_clr   = 1'b1;
                bit_cnt_d = '0;
                if (rx_s_q) begin
                    espera_d = 1'b0;
                end else if (!espera_q) begin
                    estado_d = START;
                end
            end
            START: begin
                tmr_en = 1'b1;
                if (tmr_meio) begin
                    tmr_clr  = 1'b1;
                    estado_d = rx_s_q ? INICIAL : DADOS;
                end
            end
            DADOS: begin
                tmr_en = 1'b1;
                if (tmr_fim) begin
                    shift_d   = {rx_s_q, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                        estado_d = PARIDADE;
`else
                        estado_d = STOP;
`endif
                    end
                end
            end
`ifdef RECEPTOR_PARIDADE_EN
            PARIDADE: begin
                tmr_en = 1'b1;
                if (tmr_fim) begin
                    par_d    = rx_s_q;
                    estado_d = STOP;
                end
            end
`endif
            STOP: begin
                tmr_en = 1'b1;
                if (tmr_fim) begin
`ifdef RECEPTOR_PARIDADE_EN
                    estado_d = (rx_s_q && !paridade_impar(shift_q, par_q)) ? ARMAZENA : ERRO;
`else
                    estado_d = rx_s_q ? ARMAZENA : ERRO;
`endif
                end
            end
            ARMAZENA: begin
                tmr_clr = 1'b1;
                if (!cnt_byte_q) begin
                    low_d      = shift_q;
                    cnt_byte_d = 1'b1;
                    estado_d   = INICIAL;
                end else begin
                    d_d        = {shift_q, low_q};
                    cnt_byte_d = 1'b0;
                    estado_d   = PRONTO;
                end
            end
            PRONTO: begin
                tmr_clr  = 1'b1;
                estado_d = INICIAL;
            end
            ERRO: begin
                // Only block new starts if the line is still low after the bad frame.
                tmr_clr    = 1'b1;
                cnt_byte_d = 1'b0;
                espera_d   = ~rx_s_q;
                estado_d   = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        pronto_d = (estado_d == PRONTO);
        erro_d   = (estado_d == ERRO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            estado_q   <= INICIAL;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            low_q      <= '0;
            cnt_byte_q <= 1'b0;
            espera_q   <= 1'b0;
            d_q        <= '0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
            par_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= RX;
            rx_s_q     <= rx_meta_q;
            estado_q   <= estado_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            low_q      <= low_d;
            cnt_byte_q <= cnt_byte_d;
            espera_q   <= espera_d;
            d_q        <= d_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
`ifdef RECEPTOR_PARIDADE_EN
            par_q      <= par_d;
`endif
        end
    end

    assign D         = d_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_receptor_serial_16.sv
// Bench for receptor_serial_16: frame-level model predicts the word/error event stream
// and the value D must hold; a negedge monitor checks the DUT against it every cycle.
module tb_receptor_serial_16;

    localparam int unsigned CPB = 4;
`ifdef RECEPTOR_PARIDADE_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        is_err;
        logic [15:0] word;
    } evt_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        RX    = 1'b1;
    logic [15:0] D;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pronto = 0;
    int          n_erro   = 0;
    evt_t        evq[$];
    logic [15:0] got_words[$];
    logic [15:0] exp_d  = 16'h0;
    bit          pend_v = 1'b0;
    logic [7:0]  pend_b = 8'h0;
    bit          checking = 1'b0;
    evt_t        cmp_e;

    receptor_serial_16 #(.CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .RX        (RX),
        .D         (D),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event monitor: every pulse must match the next predicted event; D must track the model.
    always @(negedge clock) begin
        if (checking) begin
            if (pronto || erro) begin
                if (evq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: pronto=%0b erro=%0b D=%h, none expected (t=%0t)",
                             pronto, erro, D, $time);
                end else begin
                    cmp_e = evq.pop_front();
                    check("event_kind", {30'd0, pronto, erro}, cmp_e.is_err ? 32'd1 : 32'd2);
                    if (!cmp_e.is_err) begin
                        exp_d = cmp_e.word;
                        n_pronto++;
                        got_words.push_back(D);
                    end else begin
                        n_erro++;
                    end
                end
            end
            check("D_value", {16'd0, D}, {16'd0, exp_d});
        end
    end

    task automatic send_bit(input logic b);
        RX = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Predict the frame's effect, then drive start, 8 data bits LSB first, [parity], stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        evt_t e;
        bit   err;
        err = !stop_ok || (PAR_EN && !par_ok);
        if (err) begin
            e.is_err = 1'b1;
            e.word   = 16'h0;
            evq.push_back(e);
            pend_v = 1'b0;
        end else if (!pend_v) begin
            pend_v = 1'b1;
            pend_b = b;
        end else begin
            e.is_err = 1'b0;
            e.word   = {b, pend_b};
            evq.push_back(e);
            pend_v = 1'b0;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (PAR_EN) send_bit(par_ok ? ^b : ~^b);
        send_bit(stop_ok);
    endtask

    initial begin
        int base;

        // Reset values
        reset = 1'b1;
        RX    = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_D", {16'd0, D}, 32'h0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_erro", {31'd0, erro}, 32'd0);
        check("rst_estado", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        checking = 1'b1;
        idle(2 * CPB);

        // Normal word with exact latency: pronto on the 2nd negedge after the stop bit ends
        send_frame(8'h5A, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1);
        @(negedge clock);
        check("lat_pronto_early", {31'd0, pronto}, 32'd0);
        @(negedge clock);
        check("lat_pronto", {31'd0, pronto}, 32'd1);
        check("word_A55A", {16'd0, D}, 32'h0000_A55A);
        @(negedge clock);
        check("pronto_one_cycle", {31'd0, pronto}, 32'd0);
        idle(2 * CPB);
        check("t1_erro_cnt", n_erro, 32'd0);

        // Back-to-back words with no idle gap
        base = got_words.size();
        send_frame(8'h34, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'hCD, 1'b1, 1'b1);
        send_frame(8'hAB, 1'b1, 1'b1);
        idle(3 * CPB);
        check("b2b_count", got_words.size() - base, 32'd2);
        if (got_words.size() >= base + 2) begin
            check("b2b_word0", {16'd0, got_words[base]}, 32'h0000_1234);
            check("b2b_word1", {16'd0, got_words[base+1]}, 32'h0000_ABCD);
        end

        // Framing error on the second byte keeps D; then a fresh pair
        send_frame(8'h77, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(3 * CPB);
        check("ferr_erro_cnt", n_erro, 32'd1);
        check("ferr_D_kept", {16'd0, D}, 32'h0000_ABCD);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        idle(3 * CPB);
        check("after_err_word", {16'd0, D}, 32'h0000_0001);

        // Line stuck low after a framing error must not start a new frame
        send_frame(8'h3C, 1'b0, 1'b1);
        RX = 1'b0;
        repeat (12 * CPB) @(negedge clock);
        idle(3 * CPB);
        check("stuck_low_erro_cnt", n_erro, 32'd2);
        check("stuck_low_queue", evq.size(), 32'd0);

        // One-clock glitch in idle is a false start; pending low byte survives
        send_frame(8'h11, 1'b1, 1'b1);
        idle(CPB);
        RX = 1'b0;
        @(negedge clock);
        idle(4 * CPB);
        check("glitch_estado", {28'd0, db_estado}, 32'd0);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(3 * CPB);
        check("glitch_word", {16'd0, D}, 32'h0000_2211);

        // Reset during bit 3 of the second byte
        send_frame(8'h99, 1'b1, 1'b1);
        idle(CPB);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        RX = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        exp_d  = 16'h0;
        pend_v = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        RX    = 1'b1;
        check("midrst_D", {16'd0, D}, 32'h0);
        check("midrst_estado", {28'd0, db_estado}, 32'd0);
        idle(4 * CPB);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(3 * CPB);
        check("midrst_word", {16'd0, D}, 32'h0000_1122);

`ifdef RECEPTOR_PARIDADE_EN
        // Even parity: 0x03 with parity 0 accepted, with parity 1 rejected
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h44, 1'b1, 1'b1);
        idle(3 * CPB);
        check("par_ok_word", {16'd0, D}, 32'h0000_4403);
        base = n_erro;
        send_frame(8'h03, 1'b1, 1'b0);
        idle(3 * CPB);
        check("par_bad_erro", n_erro - base, 32'd1);
        check("par_bad_D_kept", {16'd0, D}, 32'h0000_4403);
`endif

        // Randomized frames, gaps, errors and glitches
        for (int k = 0; k < 150; k++) begin
            logic [7:0] b;
            logic       s_ok;
            logic       p_ok;
            int         gap;
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 9) != 0);
            p_ok = ($urandom_range(0, 9) != 0);
            gap  = $urandom_range(0, 3 * CPB);
            send_frame(b, s_ok, p_ok);
            if (!s_ok || (PAR_EN && !p_ok)) gap = gap + 2 * CPB;
            if (gap >= 10 && $urandom_range(0, 2) == 0) begin
                idle(2);
                RX = 1'b0;
                @(negedge clock);
                idle(gap - 3);
            end else if (gap > 0) begin
                idle(gap);
            end
        end

        idle(20 * CPB);
        check("queue_drained", evq.size(), 32'd0);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
